// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and the external data memory (slave).
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  localparam int unsigned NB = DATA_W / 8;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [NB-1:0]     dm_be;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: sized loads/stores with lane steering and extension, a req/ack data
// memory handshake with upstream stall, and fault retirement for illegal or timed-out ops.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_rden,
  input  logic              ex_wren,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic              ex_regwr,
  output logic              stall,
  mem_access_unit_if.master dm,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [DATA_W-1:0] wb_result,
  output logic [REG_AW-1:0] wb_waddr,
  output logic              wb_regwr,
  output logic              wb_fault
);
  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [0:0] {IDLE, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [NB-1:0]       dm_be_q, dm_be_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic [LANE_W-1:0]   op_lane_q, op_lane_d;
  logic [1:0]          op_size_q, op_size_d;
  logic                op_signed_q, op_signed_d;
  logic                op_rden_q, op_rden_d;
  logic [DATA_W-1:0]   op_result_q, op_result_d;
  logic [REG_AW-1:0]   op_waddr_q, op_waddr_d;
  logic                op_regwr_q, op_regwr_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_rdata_q, wb_rdata_d;
  logic [DATA_W-1:0]   wb_result_q, wb_result_d;
  logic [REG_AW-1:0]   wb_waddr_q, wb_waddr_d;
  logic                wb_regwr_q, wb_regwr_d;
  logic                wb_fault_q, wb_fault_d;

  // Decode of the instruction waiting in EX/MEM
  logic [LANE_W-1:0]   ex_lane;
  logic                memop;
  logic                size_ok;
  logic                misaligned;
  logic                illegal;
  logic [NB-1:0]       ex_be;
  logic [DATA_W-1:0]   ex_wdata_lane;
  logic [ADDR_W-1:0]   ex_addr_al;

  assign ex_lane       = ex_addr[LANE_W-1:0];
  assign memop         = ex_valid & (ex_rden | ex_wren);
  assign size_ok       = 32'(ex_size) <= LANE_W;
  assign misaligned    = (ex_lane & LANE_W'((32'd1 << ex_size) - 32'd1)) != '0;
  assign illegal       = ~size_ok | misaligned | (ex_rden & ex_wren);
  assign ex_be         = NB'(((32'd1 << (32'd1 << ex_size)) - 32'd1) << ex_lane);
  assign ex_wdata_lane = ex_wdata << {ex_lane, 3'b000};
  assign ex_addr_al    = {ex_addr[ADDR_W-1:LANE_W], LANE_W'(0)};

  // Load data: shift the addressed lane down, then keep the access width and extend
  logic [DATA_W-1:0]   ld_shift;
  logic [DATA_W-1:0]   ld_keep;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_msb;
  int unsigned         ld_bits;

  always_comb begin
    ld_shift = dm.dm_rdata >> {op_lane_q, 3'b000};
    ld_bits  = 32'd8 << op_size_q;
    if (ld_bits > DATA_W) ld_bits = DATA_W;
    ld_keep  = (ld_bits >= DATA_W) ? '1 : ((DATA_W'(1) << ld_bits) - DATA_W'(1));
    ld_msb   = op_signed_q & ld_shift[IDX_W'(ld_bits - 32'd1)];
    ld_data  = (ld_shift & ld_keep) | (~ld_keep & {DATA_W{ld_msb}});
  end

  // Next-state, stall and WB/bus register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_be_d     = dm_be_q;
    dm_wdata_d  = dm_wdata_q;
    op_lane_d   = op_lane_q;
    op_size_d   = op_size_q;
    op_signed_d = op_signed_q;
    op_rden_d   = op_rden_q;
    op_result_d = op_result_q;
    op_waddr_d  = op_waddr_q;
    op_regwr_d  = op_regwr_q;
    wb_valid_d  = 1'b0;
    wb_rdata_d  = wb_rdata_q;
    wb_result_d = wb_result_q;
    wb_waddr_d  = wb_waddr_q;
    wb_regwr_d  = 1'b0;
    wb_fault_d  = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (memop && !illegal) begin
          stall       = 1'b1;
          state_d     = ACCESS;
          dm_req_d    = 1'b1;
          dm_we_d     = ex_wren;
          dm_addr_d   = ex_addr_al;
          dm_be_d     = ex_be;
          dm_wdata_d  = ex_wdata_lane;
          op_lane_d   = ex_lane;
          op_size_d   = ex_size;
          op_signed_d = ex_signed;
          op_rden_d   = ex_rden;
          op_result_d = ex_result;
          op_waddr_d  = ex_waddr;
          op_regwr_d  = ex_regwr;
        end else begin
          // Non-memops and illegal memops both retire in a single cycle
          wb_valid_d  = ex_valid;
          wb_rdata_d  = '0;
          wb_result_d = ex_result;
          wb_waddr_d  = ex_waddr;
          wb_regwr_d  = ex_valid & ex_regwr & ~memop;
          wb_fault_d  = memop;
        end
      end
      ACCESS: begin
        if (dm.dm_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Ack has priority over a coincident timeout
          state_d     = IDLE;
          cnt_d       = '0;
          dm_req_d    = 1'b0;
          dm_we_d     = 1'b0;
          wb_valid_d  = 1'b1;
          wb_rdata_d  = (dm.dm_ack && op_rden_q) ? ld_data : '0;
          wb_result_d = op_result_q;
          wb_waddr_d  = op_waddr_q;
          wb_regwr_d  = op_regwr_q & dm.dm_ack;
          wb_fault_d  = ~dm.dm_ack;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_be_q     <= '0;
      dm_wdata_q  <= '0;
      op_lane_q   <= '0;
      op_size_q   <= '0;
      op_signed_q <= 1'b0;
      op_rden_q   <= 1'b0;
      op_result_q <= '0;
      op_waddr_q  <= '0;
      op_regwr_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rdata_q  <= '0;
      wb_result_q <= '0;
      wb_waddr_q  <= '0;
      wb_regwr_q  <= 1'b0;
      wb_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_be_q     <= dm_be_d;
      dm_wdata_q  <= dm_wdata_d;
      op_lane_q   <= op_lane_d;
      op_size_q   <= op_size_d;
      op_signed_q <= op_signed_d;
      op_rden_q   <= op_rden_d;
      op_result_q <= op_result_d;
      op_waddr_q  <= op_waddr_d;
      op_regwr_q  <= op_regwr_d;
      wb_valid_q  <= wb_valid_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_result_q <= wb_result_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_regwr_q  <= wb_regwr_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_be    = dm_be_q;
  assign dm.dm_wdata = dm_wdata_q;

  assign wb_valid  = wb_valid_q;
  assign wb_rdata  = wb_rdata_q;
  assign wb_result = wb_result_q;
  assign wb_waddr  = wb_waddr_q;
  assign wb_regwr  = wb_regwr_q;
  assign wb_fault  = wb_fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected WB results, monitor pops them.
module tb_mem_access_unit;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned NB      = DATA_W / 8;

  typedef struct packed {
    logic [63:0] rdata;
    logic [63:0] result;
    logic [4:0]  waddr;
    logic        regwr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_rden, ex_wren, ex_signed, ex_regwr;
  logic [1:0]  ex_size;
  logic [63:0] ex_addr, ex_wdata, ex_result;
  logic [4:0]  ex_waddr;
  logic        stall, wb_valid, wb_regwr, wb_fault;
  logic [63:0] wb_rdata, wb_result;
  logic [4:0]  wb_waddr;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dm_bus ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rden(ex_rden), .ex_wren(ex_wren), .ex_size(ex_size),
    .ex_signed(ex_signed), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_waddr(ex_waddr), .ex_regwr(ex_regwr), .stall(stall), .dm(dm_bus.master),
    .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_result(wb_result),
    .wb_waddr(wb_waddr), .wb_regwr(wb_regwr), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference load: pick the addressed bytes one by one, then extend
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input int lane,
                                           input int bytes, input logic sg);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < bytes; b++) v[8*b +: 8] = raw[8*(lane+b) +: 8];
    if (sg && bytes < 8 && v[8*bytes-1])
      for (int b = bytes; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  // ack_at: ACCESS cycle (1-based) in which dm_ack is raised; 0 means never
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] res, input logic [4:0] wa, input logic rw,
                       input int ack_at, input logic [63:0] rdat);
    exp_t        e;
    int          bytes, lane;
    logic        memop, legal, tmo;
    logic [7:0]  be_exp;
    @(negedge clk);
    chk("idle_req", 64'(dm_bus.dm_req), 64'd0);
    ex_valid = v; ex_rden = rd; ex_wren = wr; ex_size = sz; ex_signed = sg;
    ex_addr = addr; ex_wdata = wd; ex_result = res; ex_waddr = wa; ex_regwr = rw;
    dm_bus.dm_ack   = 1'($urandom % 2);
    dm_bus.dm_rdata = {$urandom, $urandom};
    bytes = 1 << sz;
    lane  = int'(addr % 64'(NB));
    memop = v & (rd | wr);
    legal = memop && !(rd && wr) && bytes <= int'(NB) && (addr % 64'(bytes)) == 0;
    tmo   = legal && (ack_at == 0 || ack_at > int'(TIMEOUT));
    if (v) begin
      e.fault  = memop && (!legal || tmo);
      e.regwr  = rw && !e.fault;
      e.rdata  = (legal && rd && !tmo) ? ref_load(rdat, lane, bytes, sg) : 64'd0;
      e.result = res;
      e.waddr  = wa;
      sb_q.push_back(e);
    end
    #1 chk("stall_issue", 64'(stall), 64'(legal));
    if (legal) begin
      be_exp = '0;
      for (int b = 0; b < bytes; b++) be_exp[lane+b] = 1'b1;
      for (int c = 1; c <= int'(TIMEOUT); c++) begin
        @(negedge clk);
        chk("acc_req", 64'(dm_bus.dm_req), 64'd1);
        if (c == 1) begin
          chk("acc_we", 64'(dm_bus.dm_we), 64'(wr));
          chk("acc_addr", dm_bus.dm_addr, addr & ~64'(NB - 1));
          chk("acc_be", 64'(dm_bus.dm_be), 64'(be_exp));
          if (wr)
            for (int b = 0; b < bytes; b++)
              chk("acc_wdata", 64'(dm_bus.dm_wdata[8*(lane+b) +: 8]), 64'(wd[8*b +: 8]));
        end
        dm_bus.dm_ack   = (c == ack_at);
        dm_bus.dm_rdata = (c == ack_at) ? rdat : {$urandom, $urandom};
        #1 chk("stall_acc", 64'(stall), 64'(c != ack_at && c != int'(TIMEOUT)));
        if (c == ack_at) break;
      end
    end
  endtask

  // Monitor: every retired instruction must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=retire required=none t=%0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_rdata", wb_rdata, mon_e.rdata);
        chk("wb_result", wb_result, mon_e.result);
        chk("wb_waddr", 64'(wb_waddr), 64'(mon_e.waddr));
        chk("wb_regwr", 64'(wb_regwr), 64'(mon_e.regwr));
        chk("wb_fault", 64'(wb_fault), 64'(mon_e.fault));
      end
    end else if (!rst) begin
      chk("bubble_regwr", 64'(wb_regwr), 64'd0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sz;
    logic [63:0] addr;
    int          k, ra, ack_at;
    rst = 1'b1;
    ex_valid = 0; ex_rden = 0; ex_wren = 0; ex_size = 0; ex_signed = 0;
    ex_addr = 0; ex_wdata = 0; ex_result = 0; ex_waddr = 0; ex_regwr = 0;
    dm_bus.dm_ack = 0; dm_bus.dm_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_req", 64'(dm_bus.dm_req), 64'd0);
    chk("rst_we", 64'(dm_bus.dm_we), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_regwr", 64'(wb_regwr), 64'd0);
    chk("rst_wb_fault", 64'(wb_fault), 64'd0);
    rst = 1'b0;

    // Directed cases
    do_op(1, 0, 1, 2'd3, 0, 64'h0, 64'h6, 64'h11, 5'd1, 0, 1, 64'h0);
    do_op(1, 1, 0, 2'd0, 1, 64'h3, 64'h0, 64'h22, 5'd2, 1, 3, 64'h0000_0000_8000_0000);
    do_op(1, 0, 1, 2'd1, 0, 64'h6, 64'hBEEF, 64'h33, 5'd3, 0, 2, 64'h0);
    do_op(1, 1, 0, 2'd2, 0, 64'h2, 64'h0, 64'h44, 5'd4, 1, 1, 64'h0);
    do_op(1, 1, 1, 2'd3, 0, 64'h8, 64'h0, 64'h45, 5'd5, 1, 1, 64'h0);
    do_op(1, 1, 0, 2'd3, 0, 64'h10, 64'h0, 64'h55, 5'd6, 1, 0, 64'h1234);
    do_op(1, 1, 0, 2'd3, 0, 64'h18, 64'h0, 64'h66, 5'd7, 1, int'(TIMEOUT), 64'hCAFE_F00D_1234_5678);
    do_op(1, 1, 0, 2'd2, 0, 64'h24, 64'h0, 64'h67, 5'd8, 1, 1, 64'h8765_4321_0000_0000);
    do_op(1, 1, 0, 2'd1, 1, 64'h2, 64'h0, 64'h68, 5'd9, 1, 2, 64'h0000_0000_9ABC_0000);
    do_op(0, 1, 0, 2'd3, 0, 64'h0, 64'h0, 64'h69, 5'd10, 1, 1, 64'h0);

    // Reset in the middle of an access, with an ack pending in the reset cycle
    @(negedge clk);
    ex_valid = 1; ex_rden = 1; ex_wren = 0; ex_size = 2'd3; ex_addr = 64'h40; ex_regwr = 1;
    dm_bus.dm_ack = 0;
    @(negedge clk);
    chk("mid_req", 64'(dm_bus.dm_req), 64'd1);
    rst = 1'b1; dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 64'hFFFF;
    @(negedge clk);
    chk("mid_rst_req", 64'(dm_bus.dm_req), 64'd0);
    chk("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
    rst = 1'b0; ex_valid = 0; dm_bus.dm_ack = 0;
    @(negedge clk);
    chk("post_rst_wb_valid", 64'(wb_valid), 64'd0);
    do_op(1, 0, 0, 2'd0, 0, 64'h0, 64'h0, 64'h4, 5'd3, 1, 1, 64'h0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom % 8);
      sz = 2'($urandom % 4);
      addr = {$urandom, $urandom};
      if ($urandom % 5 != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      ra = int'($urandom % 10);
      ack_at = (ra == 0) ? 0 : (ra == 1) ? int'(TIMEOUT) : 1 + int'($urandom % 4);
      do_op(1'($urandom % 8 != 0), (k >= 2 && k <= 4) || k == 7, k >= 5, sz, 1'($urandom % 2),
            addr, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom % 2),
            ack_at, {$urandom, $urandom});
    end

    @(negedge clk);
    ex_valid = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
